// File: rtl/usb_pkg.sv
// Shared USB definitions: TX write-size encoding and buffer sizing constants.
package usb_pkg;

  typedef enum logic [1:0] {
    SIZE_1B = 2'd0,
    SIZE_2B = 2'd1,
    SIZE_4B = 2'd2
  } tx_size_t;

  localparam int unsigned BUF_DEPTH = 64;
  localparam int unsigned OCC_W     = 7;

  // Number of bytes carried by one AHB-side write; encoding 3 is treated as 4 bytes.
  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    case (sz)
      2'(SIZE_1B): size_bytes = 3'd1;
      2'(SIZE_2B): size_bytes = 3'd2;
      default:     size_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/tx_data_buffer.sv
// Byte-wide transmit FIFO: 1/2/4-byte little-endian writes, one-byte show-ahead pops.
module tx_data_buffer
  import usb_pkg::*;
#(
  parameter int unsigned DEPTH = BUF_DEPTH
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clear,
  input  logic             store_tx_data,
  input  logic [1:0]       tx_data_size,
  input  logic [31:0]      tx_data,
  input  logic             get_tx_packet_data,
  output logic [7:0]       tx_packet_data,
  output logic [OCC_W-1:0] buffer_occupancy,
  output logic             overflow_err,
  output logic             underflow_err
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic [OCC_W-1:0] occ;

  logic [2:0] n_bytes;
  logic       fits;
  logic       wr_ok;
  logic       pop_ok;

  // Decode write size and qualify write/pop against the pre-pop occupancy.
  always_comb begin
    n_bytes = size_bytes(tx_data_size);
    fits    = ({1'b0, occ} + 8'(n_bytes)) <= 8'(DEPTH);
    wr_ok   = store_tx_data && !clear && fits;
    pop_ok  = get_tx_packet_data && !clear && (occ != '0);
  end

  // Byte lanes land at consecutive (wrapping) addresses; storage is not reset.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (wr_ok && (3'(k) < n_bytes)) begin
        mem[wptr + PTR_W'(k)] <= tx_data[8*k +: 8];
      end
    end
  end

  // Pointers, occupancy and sticky error flags.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wptr          <= '0;
      rptr          <= '0;
      occ           <= '0;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else if (clear) begin
      wptr          <= '0;
      rptr          <= '0;
      occ           <= '0;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      if (wr_ok) begin
        wptr <= wptr + PTR_W'(n_bytes);
      end
      if (pop_ok) begin
        rptr <= rptr + PTR_W'(1);
      end
      occ <= occ + OCC_W'(wr_ok ? n_bytes : 3'd0) - OCC_W'(pop_ok);
      if (store_tx_data && !fits) begin
        overflow_err <= 1'b1;
      end
      if (get_tx_packet_data && (occ == '0)) begin
        underflow_err <= 1'b1;
      end
    end
  end

  // Head byte comes straight from state registers, zero when empty.
  assign tx_packet_data   = (occ != '0) ? mem[rptr] : 8'h00;
  assign buffer_occupancy = occ;

endmodule
